// File: rtl/s_axi_reg_pkg.sv
// Shared types and widths for the s_axi_reg register block.
//   resp_t       : 2-bit AXI response code (RESP_OKAY / RESP_SLVERR)
//   ID_W, DATA_W, ADDR_W, STRB_W : channel field widths
//   rd_state_e   : read-channel FSM states
package s_axi_reg_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    StRdIdle,
    StRdAddr,
    StRdData
  } rd_state_e;

endpackage

// File: rtl/s_axi_reg_bank.sv
// Register array for s_axi_reg: REG_NUM words of DATA_W bits.
//   clk, areset : clock, asynchronous active-high reset (clears every word)
//   we_i        : commit a write this edge
//   waddr_i     : word index to write
//   wdata_i     : write data
//   wstrb_i     : byte enables, bit n enables byte n
//   raddr_i     : word index to read
//   rdata_o     : combinational read data
module s_axi_reg_bank
  import s_axi_reg_pkg::*;
#(
  parameter int unsigned REG_NUM = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] regs_q [REG_NUM];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb_i[b]) begin
          regs_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/s_axi_reg.sv
// AXI4-style slave exposing a bank of 32-bit control/status registers.
//   clk, areset            : clock, asynchronous active-high reset
//   aw*_i / awready_o      : write address channel (awaddr is a word index)
//   w*_i / wready_o        : write data channel with byte strobes
//   b*_o / bready_i        : write response channel
//   ar*_i / arready_o      : read address channel (araddr is a word index)
//   r*_o / rready_i        : read data channel
// AW and W are captured into independent holders in either order; the write
// commits once both are full and no B response is outstanding. Out-of-range
// indices answer SLVERR without touching the array.
module s_axi_reg
  import s_axi_reg_pkg::*;
#(
  parameter int unsigned REG_NUM = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [ID_W-1:0]   awid_i,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [ID_W-1:0]   bid_o,
  output resp_t             bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [ID_W-1:0]   arid_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [ID_W-1:0]   rid_o,
  output logic [DATA_W-1:0] rdata_o,
  output resp_t             rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i
);

  // Write path state
  logic              aw_full_q, aw_full_d, awready_q, awready_d;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [ID_W-1:0]   aw_id_q;
  logic              w_full_q, w_full_d, wready_q, wready_d;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              bvalid_q, bvalid_d;
  resp_t             bresp_q, bresp_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic              aw_hs, w_hs, commit, aw_in_range;

  // Read path state
  rd_state_e         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [ID_W-1:0]   ar_id_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  resp_t             rresp_q, rresp_d;
  logic              ar_hs, ar_in_range;
  logic [DATA_W-1:0] bank_rdata;

  assign aw_hs       = awvalid_i && awready_q;
  assign w_hs        = wvalid_i && wready_q;
  assign commit      = aw_full_q && w_full_q && !bvalid_q;
  assign aw_in_range = aw_addr_q < ADDR_W'(REG_NUM);
  assign ar_hs       = arvalid_i && arready_q;
  assign ar_in_range = ar_addr_q < ADDR_W'(REG_NUM);

  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    // A holder is never captured and committed on the same edge: ready is low while full.
    if (aw_hs) begin
      aw_full_d = 1'b1;
    end else if (commit) begin
      aw_full_d = 1'b0;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
    end else if (commit) begin
      w_full_d = 1'b0;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
      bid_d    = aw_id_q;
    end else if (bvalid_q && bready_i) begin
      bvalid_d = 1'b0;
    end
    awready_d = !aw_full_d;
    wready_d  = !w_full_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      StRdIdle: if (ar_hs) rd_state_d = StRdAddr;
      StRdAddr: begin
        // Sampled on the same edge as any commit, so a colliding read sees the old value.
        rd_state_d = StRdData;
        rdata_d    = ar_in_range ? bank_rdata : '0;
        rresp_d    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      StRdData: if (rready_i) rd_state_d = StRdIdle;
      default:  rd_state_d = StRdIdle;
    endcase
    arready_d = (rd_state_d == StRdIdle);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      aw_full_q  <= 1'b0;
      awready_q  <= 1'b0;
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      w_full_q   <= 1'b0;
      wready_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      bid_q      <= '0;
      rd_state_q <= StRdIdle;
      arready_q  <= 1'b0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      aw_full_q  <= aw_full_d;
      awready_q  <= awready_d;
      w_full_q   <= w_full_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      bid_q      <= bid_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      if (aw_hs) begin
        aw_addr_q <= awaddr_i;
        aw_id_q   <= awid_i;
      end
      if (w_hs) begin
        w_data_q <= wdata_i;
        w_strb_q <= wstrb_i;
      end
      if (ar_hs) begin
        ar_addr_q <= araddr_i;
        ar_id_q   <= arid_i;
      end
    end
  end

  s_axi_reg_bank #(
    .REG_NUM(REG_NUM),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk    (clk),
    .areset (areset),
    .we_i   (commit && aw_in_range),
    .waddr_i(aw_addr_q[IDX_W-1:0]),
    .wdata_i(w_data_q),
    .wstrb_i(w_strb_q),
    .raddr_i(ar_addr_q[IDX_W-1:0]),
    .rdata_o(bank_rdata)
  );

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign bid_o     = bid_q;
  assign arready_o = arready_q;
  assign rvalid_o  = (rd_state_q == StRdData);
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rid_o     = ar_id_q;

endmodule

// File: tb/tb_s_axi_reg.sv
// Directed bench for s_axi_reg: a table of write/read-back vectors plus
// hand-written sequences for ordering, back-pressure, collision and reset.
module tb_s_axi_reg;
  import s_axi_reg_pkg::*;

  logic              clk, areset;
  logic [ID_W-1:0]   awid_i, bid_o, arid_i, rid_o;
  logic [ADDR_W-1:0] awaddr_i, araddr_i;
  logic              awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i;
  logic              arvalid_i, arready_o, rvalid_o, rready_i;
  logic [DATA_W-1:0] wdata_i, rdata_o;
  logic [STRB_W-1:0] wstrb_i;
  resp_t             bresp_o, rresp_o;

  s_axi_reg #(
    .REG_NUM(16),
    .IDX_W  (4)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .awid_i   (awid_i),
    .awaddr_i (awaddr_i),
    .awvalid_i(awvalid_i),
    .awready_o(awready_o),
    .wdata_i  (wdata_i),
    .wstrb_i  (wstrb_i),
    .wvalid_i (wvalid_i),
    .wready_o (wready_o),
    .bid_o    (bid_o),
    .bresp_o  (bresp_o),
    .bvalid_o (bvalid_o),
    .bready_i (bready_i),
    .arid_i   (arid_i),
    .araddr_i (araddr_i),
    .arvalid_i(arvalid_i),
    .arready_o(arready_o),
    .rid_o    (rid_o),
    .rdata_o  (rdata_o),
    .rresp_o  (rresp_o),
    .rvalid_o (rvalid_o),
    .rready_i (rready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [3:0] id);
    logic hs = 1'b0;
    awaddr_i  = a;
    awid_i    = id;
    awvalid_i = 1'b1;
    for (int n = 0; n < 20 && !hs; n++) begin
      hs = awready_o;
      tick(1);
    end
    awvalid_i = 1'b0;
    check("aw_handshake", 32'(hs), 32'd1);
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    logic hs = 1'b0;
    wdata_i  = d;
    wstrb_i  = s;
    wvalid_i = 1'b1;
    for (int n = 0; n < 20 && !hs; n++) begin
      hs = wready_o;
      tick(1);
    end
    wvalid_i = 1'b0;
    check("w_handshake", 32'(hs), 32'd1);
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [3:0] id);
    logic hs = 1'b0;
    araddr_i  = a;
    arid_i    = id;
    arvalid_i = 1'b1;
    for (int n = 0; n < 20 && !hs; n++) begin
      hs = arready_o;
      tick(1);
    end
    arvalid_i = 1'b0;
    check("ar_handshake", 32'(hs), 32'd1);
  endtask

  task automatic bpulse();
    bready_i = 1'b1;
    tick(1);
    bready_i = 1'b0;
  endtask

  task automatic rpulse();
    rready_i = 1'b1;
    tick(1);
    rready_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [3:0] id, input logic [1:0] er);
    fork
      do_aw(a, id);
      do_w(d, s);
    join
    check("wr_bvalid_early", 32'(bvalid_o), 32'd0);
    tick(1);
    check("wr_bvalid", 32'(bvalid_o), 32'd1);
    check("wr_bresp", 32'(bresp_o), 32'(er));
    check("wr_bid", 32'(bid_o), 32'(id));
    bpulse();
    check("wr_bvalid_clear", 32'(bvalid_o), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [31:0] ed,
                         input logic [1:0] er);
    do_ar(a, id);
    check("rd_arready_low", 32'(arready_o), 32'd0);
    tick(1);
    check("rd_rvalid", 32'(rvalid_o), 32'd1);
    check("rd_rdata", rdata_o, ed);
    check("rd_rresp", 32'(rresp_o), 32'(er));
    check("rd_rid", 32'(rid_o), 32'(id));
    rpulse();
    check("rd_rvalid_clear", 32'(rvalid_o), 32'd0);
    check("rd_arready_back", 32'(arready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'd3,          32'hFFFF_FFFF, 4'hF, RESP_OKAY,   32'hFFFF_FFFF, RESP_OKAY};
    vecs[1] = '{32'd3,          32'h1234_5678, 4'hA, RESP_OKAY,   32'h12FF_56FF, RESP_OKAY};
    vecs[2] = '{32'd3,          32'h0000_0000, 4'h0, RESP_OKAY,   32'h12FF_56FF, RESP_OKAY};
    vecs[3] = '{32'd15,         32'hDEAD_BEEF, 4'hF, RESP_OKAY,   32'hDEAD_BEEF, RESP_OKAY};
    vecs[4] = '{32'd0,          32'hA5A5_A5A5, 4'h1, RESP_OKAY,   32'h0000_00A5, RESP_OKAY};
    vecs[5] = '{32'd20,         32'hA3DD_DD3F, 4'hF, RESP_SLVERR, 32'h0000_0000, RESP_SLVERR};
    vecs[6] = '{32'd16,         32'h0000_0001, 4'hF, RESP_SLVERR, 32'h0000_0000, RESP_SLVERR};
    vecs[7] = '{32'h8000_0001,  32'h5555_5555, 4'hF, RESP_SLVERR, 32'h0000_0000, RESP_SLVERR};

    areset = 1'b1;
    awid_i = '0; awaddr_i = '0; awvalid_i = 1'b0;
    wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0; bready_i = 1'b0;
    arid_i = '0; araddr_i = '0; arvalid_i = 1'b0; rready_i = 1'b0;
    tick(2);
    check("rst_awready", 32'(awready_o), 32'd0);
    check("rst_wready", 32'(wready_o), 32'd0);
    check("rst_arready", 32'(arready_o), 32'd0);
    check("rst_bvalid", 32'(bvalid_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    areset = 1'b0;
    tick(1);
    check("rel_awready", 32'(awready_o), 32'd1);
    check("rel_wready", 32'(wready_o), 32'd1);
    check("rel_arready", 32'(arready_o), 32'd1);

    // Data first, address three cycles later
    do_w(32'hC2CC_EE2E, 4'hF);
    check("df_wready_low", 32'(wready_o), 32'd0);
    tick(2);
    do_aw(32'd1, 4'h3);
    check("df_bvalid_early", 32'(bvalid_o), 32'd0);
    tick(1);
    check("df_bvalid", 32'(bvalid_o), 32'd1);
    check("df_bresp", 32'(bresp_o), 32'(RESP_OKAY));
    check("df_bid", 32'(bid_o), 32'h3);
    bpulse();
    check("df_bvalid_clear", 32'(bvalid_o), 32'd0);
    check("df_wready_back", 32'(wready_o), 32'd1);

    // Read handshake with rready held low
    do_ar(32'd1, 4'h5);
    check("rh_arready_low", 32'(arready_o), 32'd0);
    check("rh_rvalid_early", 32'(rvalid_o), 32'd0);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      check("rh_rvalid_held", 32'(rvalid_o), 32'd1);
      check("rh_rdata_held", rdata_o, 32'hC2CC_EE2E);
      check("rh_rid_held", 32'(rid_o), 32'h5);
      if (i < 2) tick(1);
    end
    rpulse();
    check("rh_rvalid_clear", 32'(rvalid_o), 32'd0);
    check("rh_arready_back", 32'(arready_o), 32'd1);

    // Address first
    do_aw(32'd2, 4'h1);
    for (int i = 0; i < 2; i++) begin
      check("af_awready_low", 32'(awready_o), 32'd0);
      tick(1);
    end
    do_w(32'hF19F_4125, 4'hF);
    check("af_awready_low_w", 32'(awready_o), 32'd0);
    check("af_bvalid_early", 32'(bvalid_o), 32'd0);
    tick(1);
    check("af_bvalid", 32'(bvalid_o), 32'd1);
    check("af_bid", 32'(bid_o), 32'h1);
    check("af_awready_back", 32'(awready_o), 32'd1);
    bpulse();
    do_read(32'd2, 4'h2, 32'hF19F_4125, RESP_OKAY);

    // Back-pressure on B with a second write already captured
    fork
      do_aw(32'd4, 4'h6);
      do_w(32'h1111_1111, 4'hF);
    join
    tick(1);
    check("bp_bvalid1", 32'(bvalid_o), 32'd1);
    fork
      do_aw(32'd5, 4'h7);
      do_w(32'h2222_2222, 4'hF);
    join
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid_held", 32'(bvalid_o), 32'd1);
      check("bp_bid_held", 32'(bid_o), 32'h6);
      check("bp_bresp_held", 32'(bresp_o), 32'(RESP_OKAY));
      check("bp_awready_low", 32'(awready_o), 32'd0);
      tick(1);
    end
    bpulse();
    check("bp_bvalid_drop", 32'(bvalid_o), 32'd0);
    tick(1);
    check("bp_bvalid2", 32'(bvalid_o), 32'd1);
    check("bp_bid2", 32'(bid_o), 32'h7);
    bpulse();
    do_read(32'd4, 4'h4, 32'h1111_1111, RESP_OKAY);
    do_read(32'd5, 4'h5, 32'h2222_2222, RESP_OKAY);

    // Table: write then read back
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 4'(i), vecs[i].bresp);
      do_read(vecs[i].addr, 4'(i + 8), vecs[i].rdata, vecs[i].rresp);
    end
    // Out-of-range writes left other registers alone
    do_read(32'd1, 4'h1, 32'hC2CC_EE2E, RESP_OKAY);
    do_read(32'd0, 4'h0, 32'h0000_00A5, RESP_OKAY);

    // Commit and read of the same register on the same edge
    do_write(32'd6, 32'h0000_AAAA, 4'hF, 4'h2, RESP_OKAY);
    do_aw(32'd6, 4'h9);
    fork
      do_ar(32'd6, 4'hA);
      do_w(32'hBBBB_BBBB, 4'hF);
    join
    tick(1);
    check("col_bvalid", 32'(bvalid_o), 32'd1);
    check("col_rvalid", 32'(rvalid_o), 32'd1);
    check("col_rdata_old", rdata_o, 32'h0000_AAAA);
    bpulse();
    rpulse();
    do_read(32'd6, 4'hB, 32'hBBBB_BBBB, RESP_OKAY);

    // Reset in the middle of a read and a half-captured write
    do_aw(32'd7, 4'h1);
    do_ar(32'd1, 4'h3);
    tick(1);
    check("mr_rvalid", 32'(rvalid_o), 32'd1);
    #2 areset = 1'b1;
    #1;
    check("mr_rvalid_rst", 32'(rvalid_o), 32'd0);
    check("mr_arready_rst", 32'(arready_o), 32'd0);
    check("mr_awready_rst", 32'(awready_o), 32'd0);
    tick(1);
    areset = 1'b0;
    tick(1);
    check("mr_awready_back", 32'(awready_o), 32'd1);
    check("mr_arready_back", 32'(arready_o), 32'd1);
    check("mr_bvalid", 32'(bvalid_o), 32'd0);
    do_read(32'd1, 4'h1, 32'h0, RESP_OKAY);
    do_read(32'd2, 4'h2, 32'h0, RESP_OKAY);
    do_read(32'd6, 4'h6, 32'h0, RESP_OKAY);
    do_read(32'd15, 4'hF, 32'h0, RESP_OKAY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
